// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin sharing of one pipelined FP less-than
// comparator among NREQ requesters. Each issued compare carries its
// requester ID down a LAT-deep tag pipeline so the comparator result
// can be steered back to the requester that issued it.
module cmp_share_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 23,
   parameter int LAT  = 3,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   gnt,
   output logic [W-1:0]      cmp_a,
   output logic [W-1:0]      cmp_b,
   input  logic              cmp_less,
   output logic [NREQ-1:0]   rsp_valid,
   output logic              rsp_less,
   output logic [IDW-1:0]    rsp_id,
   output logic              busy
);

   // Packed per-requester operand views; slice i is requester i.
   logic [NREQ-1:0][W-1:0] opa, opb;
   assign opa = req_a;
   assign opb = req_b;

   logic [IDW-1:0]           ptr;       // last winner
   logic [NREQ-1:0]          elig;
   logic [IDW-1:0]           win;
   logic                     win_vld;
   logic [LAT:1]             vld_pipe;
   logic [LAT:1][IDW-1:0]    id_pipe;

   // The grant register doubles as the mask: a requester granted at the
   // previous edge is still reacting to gnt and must not be re-issued.
   assign elig = req & ~gnt;

   // Round-robin pick: first eligible index searching up from ptr+1.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!win_vld && elig[(int'(ptr) + 1 + i) % NREQ]) begin
            win_vld = 1'b1;
            win     = IDW'((int'(ptr) + 1 + i) % NREQ);
         end
      end
   end

   // Issue stage: grant pulse, operand registers, pointer update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt   <= '0;
         cmp_a <= '0;
         cmp_b <= '0;
         ptr   <= IDW'(NREQ - 1);   // so requester 0 is searched first
      end else begin
         gnt <= '0;
         if (win_vld) begin
            gnt[win] <= 1'b1;
            cmp_a    <= opa[win];
            cmp_b    <= opb[win];
            ptr      <= win;
         end
      end
   end

   // Tag pipeline: shifts every cycle, no stall, tracks the comparator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe[1] <= win_vld;
         if (win_vld)
            id_pipe[1] <= win;
         for (int i = 2; i <= LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            id_pipe[i]  <= id_pipe[i-1];
         end
      end
   end

   // Response stage: capture comparator result for the tag leaving the pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_less  <= 1'b0;
         rsp_id    <= '0;
      end else begin
         rsp_valid <= '0;
         if (vld_pipe[LAT]) begin
            rsp_valid[id_pipe[LAT]] <= 1'b1;
            rsp_id                  <= id_pipe[LAT];
            rsp_less                <= cmp_less;
         end
      end
   end

   assign busy = |vld_pipe;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter with a small behavioural
// comparator (LAT-1 result registers behind the operand registers).
module tb_cmp_share_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 23;
   localparam int LAT  = 3;
   localparam int IDW  = 2;
   localparam logic [W-1:0] ONE = 23'h27FE00;
   localparam logic [W-1:0] TWO = 23'h280000;

   logic              clk, rst;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0][W-1:0] ra, rb;
   logic [NREQ-1:0]   gnt;
   logic [W-1:0]      cmp_a, cmp_b;
   logic              cmp_less;
   logic [NREQ-1:0]   rsp_valid;
   logic              rsp_less;
   logic [IDW-1:0]    rsp_id;
   logic              busy;

   int n_chk = 0;
   int n_fail = 0;

   cmp_share_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_a(ra), .req_b(rb),
      .gnt(gnt), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_less(cmp_less),
      .rsp_valid(rsp_valid), .rsp_less(rsp_less), .rsp_id(rsp_id),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // less = 1 only when both operands are normal and A < B strictly.
   function automatic logic fless(input logic [W-1:0] a, input logic [W-1:0] b);
      logic sa, sb;
      logic [19:0] ma, mb;
      sa = a[20]; sb = b[20]; ma = a[19:0]; mb = b[19:0];
      if (a[22:21] != 2'b01 || b[22:21] != 2'b01) return 1'b0;
      if (sa != sb) return sa;
      if (!sa) return ma < mb;
      return ma > mb;
   endfunction

   // Comparator model: result registered LAT-1 times after the operand regs.
   logic [LAT-2:0] cq;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cq <= '0;
      else     cq <= {cq[LAT-3:0], fless(cmp_a, cmp_b)};
   end
   assign cmp_less = cq[LAT-2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic do_single(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic exp_less);
      ra[idx] = a; rb[idx] = b; req = '0; req[idx] = 1'b1;
      step();
      chk("single_gnt", 32'(gnt), 32'(1 << idx));
      chk("single_cmpa", 32'(cmp_a), 32'(a));
      chk("single_busy1", 32'(busy), 1);
      req = '0;
      for (int c = 2; c <= LAT; c++) begin
         step();
         chk("single_gnt_off", 32'(gnt), 0);
         chk("single_busy", 32'(busy), 1);
         chk("single_norsp", 32'(rsp_valid), 0);
      end
      step();
      chk("single_rspv", 32'(rsp_valid), 32'(1 << idx));
      chk("single_less", 32'(rsp_less), 32'(exp_less));
      chk("single_id", 32'(rsp_id), 32'(idx));
      chk("single_busy0", 32'(busy), 0);
      step();
      chk("single_rsp_pulse", 32'(rsp_valid), 0);
   endtask

   // Round-robin expectations, cycles 1..8.
   int rr_gnt [1:8] = '{1, 2, 4, 8, 1, 0, 0, 0};
   int rr_rsp [1:8] = '{0, 0, 0, 1, 2, 4, 8, 1};
   int rr_id  [1:8] = '{0, 0, 0, 0, 1, 2, 3, 0};
   int rr_ls  [1:8] = '{0, 0, 0, 1, 0, 0, 1, 1};
   // Single requester 2 back-to-back, cycles 1..8.
   int bb_gnt [1:8] = '{4, 0, 4, 0, 4, 0, 0, 0};
   int bb_rsp [1:8] = '{0, 0, 0, 4, 0, 4, 0, 4};
   int bb_ls  [1:8] = '{0, 0, 0, 1, 0, 0, 0, 0};

   initial begin
      rst = 1'b1; req = '0; ra = '0; rb = '0;
      step();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rspv", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cmpa", 32'(cmp_a), 0);
      chk("rst_id", 32'(rsp_id), 0);
      step();
      rst = 1'b0;

      // Round-robin with all requesters held high.
      ra[0] = ONE; rb[0] = TWO;
      ra[1] = TWO; rb[1] = ONE;
      ra[2] = ONE; rb[2] = ONE;
      ra[3] = ONE; rb[3] = TWO;
      req = 4'b1111;
      for (int c = 1; c <= 8; c++) begin
         step();
         chk("rr_gnt", 32'(gnt), 32'(rr_gnt[c]));
         chk("rr_rspv", 32'(rsp_valid), 32'(rr_rsp[c]));
         if (rr_rsp[c] != 0) begin
            chk("rr_id", 32'(rsp_id), 32'(rr_id[c]));
            chk("rr_less", 32'(rsp_less), 32'(rr_ls[c]));
         end
         if (c == 5) req = '0;
      end

      // Single requests: less, swapped, equal, and a different requester.
      do_single(0, ONE, TWO, 1'b1);
      do_single(0, TWO, ONE, 1'b0);
      do_single(0, ONE, ONE, 1'b0);
      do_single(3, ONE, TWO, 1'b1);

      // Requester 2 alone, new operands presented during each gnt.
      ra[2] = ONE; rb[2] = TWO; req = 4'b0100;
      for (int c = 1; c <= 8; c++) begin
         step();
         chk("bb_gnt", 32'(gnt), 32'(bb_gnt[c]));
         chk("bb_rspv", 32'(rsp_valid), 32'(bb_rsp[c]));
         if (bb_rsp[c] != 0) begin
            chk("bb_id", 32'(rsp_id), 2);
            chk("bb_less", 32'(rsp_less), 32'(bb_ls[c]));
         end
         if (c == 1) begin ra[2] = TWO; rb[2] = ONE; end
         if (c == 3) begin ra[2] = ONE; rb[2] = ONE; end
         if (c == 5) req = '0;
      end

      // Reset mid-flight: three issues, reset with two still in flight.
      ra[0] = ONE; rb[0] = TWO; ra[1] = ONE; rb[1] = TWO; ra[2] = ONE; rb[2] = TWO;
      req = 4'b0111;
      step(); step(); step();
      chk("mf_gnt3", 32'(gnt), 4);
      req = '0;
      step();
      chk("mf_rsp0", 32'(rsp_valid), 1);
      chk("mf_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      chk("mf_rst_gnt", 32'(gnt), 0);
      chk("mf_rst_rspv", 32'(rsp_valid), 0);
      chk("mf_rst_less", 32'(rsp_less), 0);
      chk("mf_rst_id", 32'(rsp_id), 0);
      chk("mf_rst_busy", 32'(busy), 0);
      chk("mf_rst_cmpa", 32'(cmp_a), 0);
      chk("mf_rst_cmpb", 32'(cmp_b), 0);
      step();
      rst = 1'b0;
      for (int c = 0; c < LAT + 2; c++) begin
         step();
         chk("mf_no_rsp", 32'(rsp_valid), 0);
      end
      req = 4'b1001;
      step();
      chk("mf_first_gnt", 32'(gnt), 1);
      req = '0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/cmp_share_arbiter.md
Name: cmp_share_arbiter

Overview:
- Shares one pipelined floating-point less-than comparator among NREQ requesters (slab min/max units in the Ray-AABB core).
- Round-robin arbitration issues at most one compare per cycle.
- Tags each issued compare with its requester ID through a LAT-deep shift register and routes the registered result back to that requester.
- The comparator instance sits outside this block, wired through cmp_a, cmp_b and cmp_less.

Parameters:
- NREQ, 4, number of requesters; 2 to 8.
- W, 23, operand width: 2 exception bits, sign, 11-bit exponent, 9-bit fraction.
- LAT, 3, cycles from an operand-register edge to the edge at which cmp_less holds that result. Equals the FPSub pipeline depth plus 1 (the less register). Must be ≥1.
- IDW, 2, requester-ID width, equal to clog2(NREQ).

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous, active-high reset.
- req, input, NREQ, per-requester request; held high with stable operands until gnt.
- req_a, input, NREQ*W, packed A operands; slice i belongs to requester i.
- req_b, input, NREQ*W, packed B operands.
- gnt, output, NREQ, one-hot registered grant, one-cycle pulse.
- cmp_a, output, W, registered A operand to the comparator.
- cmp_b, output, W, registered B operand to the comparator.
- cmp_less, input, 1, comparator result (1 means A<B).
- rsp_valid, output, NREQ, one-hot result strobe, one cycle.
- rsp_less, output, 1, result for the strobed requester.
- rsp_id, output, IDW, ID of the strobed requester.
- busy, output, 1, high while any compare is in flight.

Behaviour:
- Reset (async): clears gnt, rsp_valid, rsp_less, rsp_id, busy, cmp_a, cmp_b, all tag stages and their valid bits, and the mask. The RR pointer resets so requester 0 has highest priority.
- Eligibility: eligible = req & ~mask. mask holds the one-hot grant issued at the previous edge. A requester granted at edge k is therefore ignored at edge k+1 (no double issue while it reacts to gnt). It may present new operands with req high during its gnt cycle; these are eligible at edge k+2.
- Arbitration at each edge: if eligible≠0, the winner w is the first eligible index searching upward from (last winner + 1) mod NREQ. On a win:
  - gnt ← onehot(w).
  - cmp_a ← req_a[w], cmp_b ← req_b[w].
  - tag stage 1 ← {valid=1, id=w}.
  - RR pointer ← w.
- If eligible=0: gnt ← 0, tag stage 1 valid ← 0, cmp_a/cmp_b hold their value, RR pointer holds.
- Tag pipeline: LAT stages shift every cycle unconditionally; no stall and no backpressure.
- Response: at edge k+LAT, for a compare issued at edge k:
  - If tag stage LAT valid: rsp_valid ← onehot(id), rsp_id ← id, rsp_less ← cmp_less.
  - Otherwise rsp_valid ← 0, and rsp_less/rsp_id hold.
  - Total request-edge to rsp_valid latency is LAT cycles after gnt rises.
- Ordering: responses return in issue order. Multiple compares from different requesters may be in flight; one requester may have several in flight, spaced at least 2 cycles apart.
- busy = OR of all tag valid bits, combinational from registers.
- Throughput: one compare per cycle when two or more requesters alternate; one per 2 cycles for a single requester.
- Reset mid-flight: in-flight tags are discarded and no rsp_valid is produced for them. Requesters must re-request.
- req dropped before gnt: the request is simply not issued; no error.
- Operand semantics are not interpreted. NaN, zero and infinity handling is whatever the comparator produces (less=1 only for a normal negative difference).

Test Plan:
- Bench pairs this block with the real comparator (FPSub depth 2, LAT=3). Encodings: 1.0 = 0x27FE00, 2.0 = 0x280000.
- Single request: req[0]=1, A=0x27FE00, B=0x280000. Expect gnt[0] 1 cycle later, and rsp_valid[0]=1, rsp_less=1, rsp_id=0 exactly LAT cycles after gnt. busy high in between.
- Swapped and equal operands: A=0x280000, B=0x27FE00 → rsp_less=0. A=B=0x27FE00 → rsp_less=0 (zero result has exception bits 00).
- Round-robin fairness: all 4 req held high. Expect gnt order 0,1,2,3,0 on consecutive cycles. No requester is granted on two consecutive cycles, and responses stream one per cycle with rsp_id 0,1,2,3.
- Single-requester back-to-back: req[2] held high with a new operand pair each gnt. Expect gnt[2] every other cycle and the matching rsp_less sequence in order.
- Reset mid-flight: issue 3 compares, assert rst while 2 are in flight. Expect all outputs 0 immediately, no rsp_valid after release, and the next grant goes to requester 0 first.
